// File: rtl/calendar_sequencer_if.sv
// rtl/calendar_sequencer_if.sv - date control and status bundle for calendar_sequencer
interface calendar_sequencer_if #(
  parameter int YEAR_W = 12
);
  logic              tick;
  logic              load;
  logic [4:0]        load_day;
  logic [3:0]        load_month;
  logic [YEAR_W-1:0] load_year;
  logic [4:0]        day;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic              eom;
  logic              eoy;
  logic              load_err;

  modport master (
    output tick, load, load_day, load_month, load_year,
    input  day, month, year, leap, eom, eoy, load_err
  );

  modport slave (
    input  tick, load, load_day, load_month, load_year,
    output day, month, year, leap, eom, eoy, load_err
  );
endinterface

// File: rtl/calendar_sequencer.sv
// rtl/calendar_sequencer.sv - day/month/year counter sequencing the days_counter month-length decoder
module calendar_sequencer #(
  parameter int YEAR_W     = 12,
  parameter int RESET_YEAR = 2000
) (
  input logic                clk,
  input logic                rst,
  calendar_sequencer_if.slave bus
);
  logic [4:0]        day_q;
  logic [3:0]        month_q;
  logic [YEAR_W-1:0] year_q;
  logic              eom_q, eoy_q, load_err_q;
  logic              leap_cur, leap_ld;
  logic              c28, c29, c30, c31;
  logic              l28, l29, l30, l31;
  logic [4:0]        last_day, load_last_day;
  logic              load_ok;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    int unsigned yi;
    yi = 32'(y);
    return ((yi % 4) == 0) && (((yi % 100) != 0) || ((yi % 400) == 0));
  endfunction

  // Any pattern other than exactly one hot output falls back to a 31-day month.
  function automatic logic [4:0] month_len(input logic a28, a29, a30, a31);
    case ({a31, a30, a29, a28})
      4'b0001: return 5'd28;
      4'b0010: return 5'd29;
      4'b0100: return 5'd30;
      default: return 5'd31;
    endcase
  endfunction

  assign leap_cur = is_leap(year_q);
  assign leap_ld  = is_leap(bus.load_year);

  days_counter u_cur_len (
    .month (month_q),
    .leap  (leap_cur),
    .m28   (c28),
    .m29   (c29),
    .m30   (c30),
    .m31   (c31)
  );

  days_counter u_load_len (
    .month (bus.load_month),
    .leap  (leap_ld),
    .m28   (l28),
    .m29   (l29),
    .m30   (l30),
    .m31   (l31)
  );

  assign last_day      = month_len(c28, c29, c30, c31);
  assign load_last_day = month_len(l28, l29, l30, l31);
  assign load_ok       = (bus.load_month >= 4'd1) && (bus.load_month <= 4'd12) &&
                         (bus.load_day != 5'd0) && (bus.load_day <= load_last_day);

  always_ff @(posedge clk) begin
    if (rst) begin
      day_q      <= 5'd1;
      month_q    <= 4'd1;
      year_q     <= YEAR_W'(RESET_YEAR);
      eom_q      <= 1'b0;
      eoy_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      eom_q      <= 1'b0;
      eoy_q      <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        // A rejected load still claims the cycle, so a coincident tick is lost.
        if (load_ok) begin
          day_q   <= bus.load_day;
          month_q <= bus.load_month;
          year_q  <= bus.load_year;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (bus.tick) begin
        if (day_q < last_day) begin
          day_q <= day_q + 5'd1;
        end else begin
          day_q <= 5'd1;
          eom_q <= 1'b1;
          if (month_q < 4'd12) begin
            month_q <= month_q + 4'd1;
          end else begin
            month_q <= 4'd1;
            year_q  <= year_q + 1'b1;
            eoy_q   <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.day      = day_q;
  assign bus.month    = month_q;
  assign bus.year     = year_q;
  assign bus.leap     = leap_cur;
  assign bus.eom      = eom_q;
  assign bus.eoy      = eoy_q;
  assign bus.load_err = load_err_q;
endmodule

module days_counter (
  input  logic [3:0] month,
  input  logic       leap,
  output logic       m28,
  output logic       m29,
  output logic       m30,
  output logic       m31
);
  always_comb begin
    m28 = 1'b0;
    m29 = 1'b0;
    m30 = 1'b0;
    m31 = 1'b0;
    case (month)
      4'd2: begin
        if (leap) m29 = 1'b1;
        else      m28 = 1'b1;
      end
      4'd4, 4'd6, 4'd9, 4'd11:                   m30 = 1'b1;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: m31 = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_calendar_sequencer.sv
// tb/tb_calendar_sequencer.sv - directed vector bench for calendar_sequencer
module tb_calendar_sequencer;
  localparam int YEAR_W = 12;

  typedef struct {
    logic              rst;
    logic              load;
    logic              tick;
    logic [4:0]        ld_day;
    logic [3:0]        ld_month;
    logic [YEAR_W-1:0] ld_year;
    logic [4:0]        e_day;
    logic [3:0]        e_month;
    logic [YEAR_W-1:0] e_year;
    logic              e_leap;
    logic              e_eom;
    logic              e_eoy;
    logic              e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  calendar_sequencer_if #(.YEAR_W(YEAR_W)) bus ();

  calendar_sequencer #(.YEAR_W(YEAR_W), .RESET_YEAR(2000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, l, t, input int ld, lm, ly,
                              input int ed, em, ey, input logic lp, eo, ey1, er);
    vec_t v;
    v.rst = r; v.load = l; v.tick = t;
    v.ld_day = 5'(ld); v.ld_month = 4'(lm); v.ld_year = YEAR_W'(ly);
    v.e_day = 5'(ed); v.e_month = 4'(em); v.e_year = YEAR_W'(ey);
    v.e_leap = lp; v.e_eom = eo; v.e_eoy = ey1; v.e_err = er;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input vec_t v);
    logic [YEAR_W+12:0] act, exp;
    act = {bus.day, bus.month, bus.year, bus.leap, bus.eom, bus.eoy, bus.load_err};
    exp = {v.e_day, v.e_month, v.e_year, v.e_leap, v.e_eom, v.e_eoy, v.e_err};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d/%0d/%0d leap=%b eom=%b eoy=%b err=%b, want %0d/%0d/%0d leap=%b eom=%b eoy=%b err=%b",
               name, bus.day, bus.month, bus.year, bus.leap, bus.eom, bus.eoy, bus.load_err,
               v.e_day, v.e_month, v.e_year, v.e_leap, v.e_eom, v.e_eoy, v.e_err);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    rst            = v.rst;
    bus.load       = v.load;
    bus.tick       = v.tick;
    bus.load_day   = v.ld_day;
    bus.load_month = v.ld_month;
    bus.load_year  = v.ld_year;
    @(posedge clk);
    #1;
    check(name, v);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; bus.load = 1'b0; bus.tick = 1'b0;
    bus.load_day = '0; bus.load_month = '0; bus.load_year = '0;

    add(1,0,0, 0,0,0,       1,1,2000, 1,0,0,0);
    apply("reset", vq[0]);

    // January walk: 30 ticks reach day 31, the next rolls into February.
    for (int i = 2; i <= 31; i++) begin
      add(0,0,1, 0,0,0, i,1,2000, 1,0,0,0);
      apply($sformatf("jan_day%0d", i), vq[vq.size()-1]);
    end
    add(0,0,1, 0,0,0, 1,2,2000, 1,1,0,0); apply("jan_rollover", vq[vq.size()-1]);
    add(0,0,0, 0,0,0, 1,2,2000, 1,0,0,0); apply("eom_one_cycle", vq[vq.size()-1]);
    vq.delete();

    add(0,1,0, 28,2,2024,  28,2,2024, 1,0,0,0);
    add(0,0,1, 0,0,0,      29,2,2024, 1,0,0,0);
    add(0,0,1, 0,0,0,       1,3,2024, 1,1,0,0);
    add(0,1,0, 28,2,2023,  28,2,2023, 0,0,0,0);
    add(0,0,1, 0,0,0,       1,3,2023, 0,1,0,0);
    add(0,1,0, 28,2,1900,  28,2,1900, 0,0,0,0);
    add(0,0,1, 0,0,0,       1,3,1900, 0,1,0,0);
    add(0,1,0, 28,2,2000,  28,2,2000, 1,0,0,0);
    add(0,0,1, 0,0,0,      29,2,2000, 1,0,0,0);
    add(0,1,0, 29,2,2024,  29,2,2024, 1,0,0,0);
    add(0,1,0, 30,4,2023,  30,4,2023, 0,0,0,0);
    add(0,0,1, 0,0,0,       1,5,2023, 0,1,0,0);
    add(0,1,0, 31,12,2023, 31,12,2023, 0,0,0,0);
    add(0,0,1, 0,0,0,       1,1,2024, 1,1,1,0);
    add(0,0,0, 0,0,0,       1,1,2024, 1,0,0,0);
    add(0,1,0, 31,12,4095, 31,12,4095, 0,0,0,0);
    add(0,0,1, 0,0,0,       1,1,0,    1,1,1,0);
    add(0,1,0, 15,6,2023,  15,6,2023, 0,0,0,0);
    add(0,1,0, 30,2,2024,  15,6,2023, 0,0,0,1);
    add(0,1,0, 31,4,2023,  15,6,2023, 0,0,0,1);
    add(0,1,0, 0,5,2023,   15,6,2023, 0,0,0,1);
    add(0,1,0, 15,13,2023, 15,6,2023, 0,0,0,1);
    add(0,0,0, 0,0,0,      15,6,2023, 0,0,0,0);
    add(0,1,1, 10,7,2023,  10,7,2023, 0,0,0,0);
    add(0,1,1, 31,4,2023,  10,7,2023, 0,0,0,1);
    add(0,1,0, 20,8,2023,  20,8,2023, 0,0,0,0);
    add(1,1,1, 5,5,2023,    1,1,2000, 1,0,0,0);
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      apply($sformatf("vec%0d", i), v);
    end

    v = vq[vq.size()-1];
    v.rst = 0; v.load = 0; v.tick = 0;
    for (int i = 0; i < 10; i++) apply($sformatf("idle%0d", i), v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, want finish before 50000");
    $fatal(1, "watchdog");
  end
endmodule
